// File: rtl/iic_pkg.sv
// Shared definitions for the IIC init sequencer: FSM state codes, error codes,
// transmitter state codes and the configuration table word layout.
package iic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } seq_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  localparam logic [3:0] TX_IDLE    = 4'd0;
  localparam logic [3:0] TX_ACK_CHK = 4'd7;

  localparam int TBL_W    = 23;
  localparam int DEV_MSB  = 22;
  localparam int DEV_LSB  = 16;
  localparam int WORD_MSB = 15;
  localparam int WORD_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  function automatic logic [6:0] tbl_dev(input logic [TBL_W-1:0] w);
    return w[DEV_MSB:DEV_LSB];
  endfunction

  function automatic logic [7:0] tbl_word(input logic [TBL_W-1:0] w);
    return w[WORD_MSB:WORD_LSB];
  endfunction

  function automatic logic [7:0] tbl_data(input logic [TBL_W-1:0] w);
    return w[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/iic_cfg_rom.sv
// Configuration table ROM, one-cycle registered read. Contents come from the
// INIT parameter supplied by the level that places it beside the sequencer.
module iic_cfg_rom
  import iic_pkg::*;
#(
  parameter int                         N_ENTRIES = 16,
  parameter int                         IDX_W     = 4,
  parameter logic [N_ENTRIES*TBL_W-1:0] INIT      = '0
) (
  input  logic             i_clk,
  input  logic [IDX_W-1:0] i_addr,
  output logic [TBL_W-1:0] o_data
);

  logic [TBL_W-1:0] rom_mem [N_ENTRIES];
  logic [TBL_W-1:0] data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_ENTRIES; gi++) begin : g_init
      assign rom_mem[gi] = INIT[gi*TBL_W +: TBL_W];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    data_reg <= rom_mem[i_addr];
  end

  assign o_data = data_reg;

endmodule

// File: rtl/iic_init_sequencer.sv
// Walks the configuration table and drives the single-byte IIC transmitter once
// per entry, with per-attempt watchdog, NACK retry and abort handling.
module iic_init_sequencer
  import iic_pkg::*;
#(
  parameter int N_ENTRIES   = 16,
  parameter int IDX_W       = 4,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 1024,
  parameter int GAP_CYC     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  output logic [IDX_W-1:0] o_tbl_addr,
  input  logic [TBL_W-1:0] i_tbl_data,
  output logic             o_send_en,
  output logic [6:0]       o_dev_addr,
  output logic [7:0]       o_word_addr,
  output logic [7:0]       o_write_data,
  input  logic             i_tx_done,
  input  logic [3:0]       i_tx_state,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [1:0]       o_err_code,
  output logic [IDX_W-1:0] o_err_idx
);

  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  seq_state_e       state_reg, state_next;
  logic [IDX_W:0]   idx_reg, idx_next;
  logic [3:0]       retry_reg, retry_next;
  logic [WD_W-1:0]  wdog_reg, wdog_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic [3:0]       prev_tx_state_reg;
  logic [6:0]       dev_addr_reg, dev_addr_next;
  logic [7:0]       word_addr_reg, word_addr_next;
  logic [7:0]       write_data_reg, write_data_next;
  logic [1:0]       err_code_reg, err_code_next;
  logic [IDX_W-1:0] err_idx_reg, err_idx_next;

  logic nack, timeout, last_try, gap_done, all_sent, abortable;

  // A NACK shows up as the transmitter falling from ack-check back to idle without done.
  assign nack      = (prev_tx_state_reg == TX_ACK_CHK) && (i_tx_state == TX_IDLE) && !i_tx_done;
  assign timeout   = (wdog_reg == WD_W'(TIMEOUT_CYC - 1));
  assign last_try  = ((retry_reg + 4'd1) == 4'(MAX_RETRY));
  assign gap_done  = (gap_reg == GAP_W'(GAP_CYC - 1));
  assign all_sent  = (idx_reg == (IDX_W+1)'(N_ENTRIES));
  assign abortable = state_reg inside {ST_FETCH, ST_LOAD, ST_SEND, ST_GAP};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg         <= ST_IDLE;
      idx_reg           <= '0;
      retry_reg         <= '0;
      wdog_reg          <= '0;
      gap_reg           <= '0;
      prev_tx_state_reg <= TX_IDLE;
      dev_addr_reg      <= '0;
      word_addr_reg     <= '0;
      write_data_reg    <= '0;
      err_code_reg      <= ERR_NONE;
      err_idx_reg       <= '0;
    end else begin
      state_reg         <= state_next;
      idx_reg           <= idx_next;
      retry_reg         <= retry_next;
      wdog_reg          <= wdog_next;
      gap_reg           <= gap_next;
      prev_tx_state_reg <= i_tx_state;
      dev_addr_reg      <= dev_addr_next;
      word_addr_reg     <= word_addr_next;
      write_data_reg    <= write_data_next;
      err_code_reg      <= err_code_next;
      err_idx_reg       <= err_idx_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    retry_next      = retry_reg;
    wdog_next       = wdog_reg;
    gap_next        = gap_reg;
    dev_addr_next   = dev_addr_reg;
    word_addr_next  = word_addr_reg;
    write_data_next = write_data_reg;
    err_code_next   = err_code_reg;
    err_idx_next    = err_idx_reg;
    o_send_en       = (state_reg == ST_SEND);
    o_done          = (state_reg == ST_DONE);
    o_error         = (state_reg == ST_ERR);
    o_busy          = (state_reg != ST_IDLE);

    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          idx_next      = '0;
          retry_next    = '0;
          err_code_next = ERR_NONE;
          err_idx_next  = '0;
          state_next    = ST_FETCH;
        end
      end
      ST_FETCH: state_next = ST_LOAD;
      ST_LOAD: begin
        dev_addr_next   = tbl_dev(i_tbl_data);
        word_addr_next  = tbl_word(i_tbl_data);
        write_data_next = tbl_data(i_tbl_data);
        wdog_next       = '0;
        state_next      = ST_SEND;
      end
      ST_SEND: begin
        wdog_next = wdog_reg + WD_W'(1);
        if (i_tx_done) begin
          idx_next   = idx_reg + (IDX_W+1)'(1);
          retry_next = '0;
          gap_next   = '0;
          state_next = ST_GAP;
        end else if (nack || timeout) begin
          if (last_try) begin
            err_code_next = nack ? ERR_NACK : ERR_TIMEOUT;
            err_idx_next  = idx_reg[IDX_W-1:0];
            state_next    = ST_ERR;
          end else begin
            retry_next = retry_reg + 4'd1;
            gap_next   = '0;
            state_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        gap_next = gap_reg + GAP_W'(1);
        if (gap_done) state_next = all_sent ? ST_DONE : ST_FETCH;
      end
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    // Abort overrides whatever the current state decided, including a same-cycle done.
    if (i_abort && abortable) begin
      idx_next      = idx_reg;
      retry_next    = retry_reg;
      err_code_next = ERR_ABORT;
      err_idx_next  = idx_reg[IDX_W-1:0];
      state_next    = ST_ERR;
    end
  end

  assign o_tbl_addr   = idx_reg[IDX_W-1:0];
  assign o_dev_addr   = dev_addr_reg;
  assign o_word_addr  = word_addr_reg;
  assign o_write_data = write_data_reg;
  assign o_err_code   = err_code_reg;
  assign o_err_idx    = err_idx_reg;

endmodule

// File: tb/tb_iic_init_sequencer.sv
// Scoreboard bench for iic_init_sequencer with a behavioural IIC transmitter,
// the config ROM, and an expected-transfer queue built from the table rules.
`timescale 1ns/1ps
module tb_iic_init_sequencer;
  import iic_pkg::*;

  localparam int N          = 4;
  localparam int IW         = 2;
  localparam int MAX_RETRY  = 3;
  localparam int TIMEOUT    = 64;
  localparam int GAP        = 8;
  localparam int RUN_BUDGET = 3000;
  localparam logic [N*TBL_W-1:0] TBL_INIT = {7'h48, 8'h31, 8'h0f,
                                             7'h48, 8'h30, 8'hc3,
                                             7'h1a, 8'h04, 8'h17,
                                             7'h1a, 8'h00, 8'h80};

  logic clk, i_rst, i_start, i_abort;
  logic [IW-1:0] tbl_addr, err_idx;
  logic [TBL_W-1:0] tbl_data;
  logic send_en, tx_done, busy, done, error;
  logic [6:0] dev_addr;
  logic [7:0] word_addr, write_data;
  logic [3:0] tx_state;
  logic [1:0] err_code;

  typedef struct { logic [TBL_W-1:0] word; int len; } att_t;
  typedef struct { bit is_err; logic [1:0] code; logic [IW-1:0] idx; } out_t;

  att_t exp_att[$];
  out_t exp_out[$];
  out_t last_out;
  int   nack_cfg[N];
  int   nack_left[N];
  bit   stall_mode;
  int   n_tests = 0;
  int   n_fail  = 0;

  iic_cfg_rom #(.N_ENTRIES(N), .IDX_W(IW), .INIT(TBL_INIT)) u_rom (
    .i_clk(clk), .i_addr(tbl_addr), .o_data(tbl_data)
  );

  iic_init_sequencer #(
    .N_ENTRIES(N), .IDX_W(IW), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TIMEOUT), .GAP_CYC(GAP)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .o_tbl_addr(tbl_addr), .i_tbl_data(tbl_data),
    .o_send_en(send_en), .o_dev_addr(dev_addr), .o_word_addr(word_addr),
    .o_write_data(write_data), .i_tx_done(tx_done), .i_tx_state(tx_state),
    .o_busy(busy), .o_done(done), .o_error(error),
    .o_err_code(err_code), .o_err_idx(err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [TBL_W-1:0] entry_word(input int e);
    logic [N*TBL_W-1:0] t;
    t = TBL_INIT;
    return t[e*TBL_W +: TBL_W];
  endfunction

  function automatic int find_entry(input logic [TBL_W-1:0] w);
    for (int e = 0; e < N; e++) if (entry_word(e) == w) return e;
    return -1;
  endfunction

  // Reference: entries in order, each failing min(nacks, MAX_RETRY) times; a stalled bus fails every attempt.
  function automatic void plan_run(input bit stall);
    att_t a;
    out_t o;
    o.is_err = 1'b0; o.code = ERR_NONE; o.idx = '0;
    for (int e = 0; e < N; e++) begin
      int fails;
      fails = stall ? MAX_RETRY : ((nack_cfg[e] < MAX_RETRY) ? nack_cfg[e] : MAX_RETRY);
      a.word = entry_word(e);
      a.len  = stall ? TIMEOUT : -1;
      for (int k = 0; k < fails; k++) exp_att.push_back(a);
      if (fails == MAX_RETRY) begin
        o.is_err = 1'b1; o.code = stall ? ERR_TIMEOUT : ERR_NACK; o.idx = IW'(e);
        break;
      end
      a.len = -1;
      exp_att.push_back(a);
    end
    exp_out.push_back(o);
    last_out = o;
  endfunction

  // Behavioural transmitter: a few busy states, ack check, then done or silent return to idle.
  initial begin : tx_model
    int phase;
    int cnt;
    int ent;
    bit do_nack;
    phase = 0; cnt = 0; do_nack = 1'b0;
    tx_state = TX_IDLE; tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!send_en) begin
        phase = 0; tx_state = TX_IDLE; tx_done = 1'b0;
      end else begin
        case (phase)
          0: begin
            ent = find_entry({dev_addr, word_addr, write_data});
            do_nack = 1'b0;
            if (ent >= 0 && nack_left[ent] > 0) begin
              do_nack = 1'b1;
              nack_left[ent]--;
            end
            if (stall_mode) begin
              phase = 4; tx_state = 4'd5;
            end else begin
              phase = 1; cnt = $urandom_range(1, 5); tx_state = 4'd1;
            end
          end
          1: begin
            cnt--;
            if (cnt == 0) begin tx_state = TX_ACK_CHK; phase = 2; end
            else tx_state = 4'((tx_state % 4'd6) + 4'd1);
          end
          2: begin tx_state = TX_IDLE; tx_done = !do_nack; phase = 3; end
          3: tx_done = 1'b0;
          default: tx_state = 4'd5;
        endcase
      end
    end
  end

  // Monitor: pops an expected transfer at each send_en rise and an expected outcome at each done/error pulse.
  initial begin : monitor
    bit   prev_send;
    bit   first_att;
    int   hi_len;
    int   lo_len;
    int   len_exp;
    att_t a;
    out_t o;
    prev_send = 1'b0; first_att = 1'b1; hi_len = 0; lo_len = 0; len_exp = -1;
    forever begin
      @(posedge clk); #2;
      if (i_rst) begin
        prev_send = 1'b0; first_att = 1'b1; hi_len = 0; lo_len = 0; len_exp = -1;
      end else begin
        if (send_en) begin
          if (!prev_send) begin
            $display("[TB] attempt dev=%h word=%h data=%h", dev_addr, word_addr, write_data);
            if (exp_att.size() == 0) begin
              check("unexpected_attempt", 32'(send_en), 32'd0);
              len_exp = -1;
            end else begin
              a = exp_att.pop_front();
              check("attempt_word", 32'({dev_addr, word_addr, write_data}), 32'(a.word));
              len_exp = a.len;
            end
            if (!first_att) check("gap_low_cycles", lo_len, GAP + 2);
            first_att = 1'b0;
            hi_len = 0;
          end
          hi_len++;
        end else begin
          if (prev_send && len_exp >= 0) check("send_high_cycles", hi_len, len_exp);
          if (prev_send) lo_len = 0;
          lo_len++;
        end
        prev_send = send_en;
        if (!busy && !send_en) first_att = 1'b1;
        if (done || error) begin
          if (exp_out.size() == 0) begin
            check("unexpected_outcome", 32'({done, error}), 32'd0);
          end else begin
            o = exp_out.pop_front();
            $display("[TB] outcome done=%0b error=%0b code=%0d idx=%0d", done, error, err_code, err_idx);
            check("outcome_error", 32'(error), 32'(o.is_err));
            check("outcome_done", 32'(done), 32'(!o.is_err));
            check("outcome_attempts_left", exp_att.size(), 0);
            if (o.is_err) begin
              check("outcome_code", 32'(err_code), 32'(o.code));
              check("outcome_idx", 32'(err_idx), 32'(o.idx));
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_send();
    int c;
    c = 0;
    while (!send_en && c < 50) begin step(); c++; end
    check("send_seen", 32'(send_en), 32'd1);
  endtask

  task automatic finish_run(input string tag, input int restart_at);
    int c;
    c = 0;
    while (busy && c < RUN_BUDGET) begin
      i_start = (c == restart_at);
      step();
      c++;
    end
    i_start = 1'b0;
    check("run_cycle_budget", 32'(busy), 32'd0);
    check("attempts_left", exp_att.size(), 0);
    check("outcome_left", exp_out.size(), 0);
    check("err_code_held", 32'(err_code), 32'(last_out.code));
    check("err_idx_held", 32'(err_idx), 32'(last_out.idx));
    check("pulses_low_after_run", 32'({done, error}), 32'd0);
    $display("[TB] run %s: %0d cycles, err_code=%0d err_idx=%0d", tag, c, err_code, err_idx);
  endtask

  task automatic start_run(input bit stall, input bit with_abort);
    exp_att.delete(); exp_out.delete();
    plan_run(stall);
    for (int e = 0; e < N; e++) nack_left[e] = nack_cfg[e];
    stall_mode = stall;
    i_start = 1'b1; i_abort = with_abort;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_code_cleared", 32'(err_code), 32'd0);
    check("err_idx_cleared", 32'(err_idx), 32'd0);
  endtask

  initial begin : global_limit
    #800000;
    $display("FAIL global_timeout: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "[TB] global time limit reached");
  end

  initial begin : driver
    att_t a;
    out_t o;
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; stall_mode = 1'b0;
    for (int e = 0; e < N; e++) begin nack_cfg[e] = 0; nack_left[e] = 0; end
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_send_en", 32'(send_en), 32'd0);
    check("rst_pulses", 32'({done, error}), 32'd0);
    check("rst_err", 32'({err_code, err_idx}), 32'd0);
    check("rst_tbl_addr", 32'(tbl_addr), 32'd0);
    i_rst = 1'b0;
    step();

    // All ACK; start and abort together in idle must still start the run.
    start_run(1'b0, 1'b1);
    finish_run("all_ack", -1);

    nack_cfg = '{0, 0, 1, 0};
    start_run(1'b0, 1'b0);
    finish_run("nack_once_e2", -1);

    nack_cfg = '{0, 15, 0, 0};
    start_run(1'b0, 1'b0);
    finish_run("nack_always_e1", -1);

    nack_cfg = '{0, 0, 0, 0};
    start_run(1'b1, 1'b0);
    finish_run("stall", 100);

    // Abort during entry 0: one-cycle transfer, error code abort at index 0.
    exp_att.delete(); exp_out.delete();
    a.word = entry_word(0); a.len = 1; exp_att.push_back(a);
    o.is_err = 1'b1; o.code = ERR_ABORT; o.idx = '0; exp_out.push_back(o); last_out = o;
    for (int e = 0; e < N; e++) nack_left[e] = 0;
    stall_mode = 1'b0;
    i_start = 1'b1; step(); i_start = 1'b0;
    wait_send();
    i_abort = 1'b1; step(); i_abort = 1'b0;
    check("abort_send_low", 32'(send_en), 32'd0);
    check("abort_error_pulse", 32'(error), 32'd1);
    check("abort_code", 32'(err_code), 32'(ERR_ABORT));
    finish_run("abort_e0", -1);

    start_run(1'b0, 1'b0);
    finish_run("after_abort", 7);

    // Reset in the middle of a transfer.
    start_run(1'b0, 1'b0);
    wait_send();
    repeat ($urandom_range(0, 1)) step();
    i_rst = 1'b1; step();
    check("midrst_send_en", 32'(send_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pulses", 32'({done, error}), 32'd0);
    check("midrst_err", 32'({err_code, err_idx}), 32'd0);
    check("midrst_tbl_addr", 32'(tbl_addr), 32'd0);
    check("midrst_xfer_regs", 32'({dev_addr, word_addr, write_data}), 32'd0);
    i_rst = 1'b0;
    exp_att.delete(); exp_out.delete();
    step();
    start_run(1'b0, 1'b0);
    finish_run("after_reset", 20);

    for (int r = 0; r < 8; r++) begin
      bit stall;
      for (int e = 0; e < N; e++)
        nack_cfg[e] = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 3);
      stall = ($urandom_range(0, 7) == 0);
      start_run(stall, 1'b0);
      finish_run($sformatf("random_%0d", r), $urandom_range(2, 60));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
